shared_nibble_adder_ctrl: RTL and testbench

- Arbitrates two requesters onto one shared combinational 4-bit adder (4-bit a/b in, 5-bit sum out, no carry-in).
- Performs a W = 4*NIBBLES bit addition nibble-serially, least-significant nibble first.
- The adder has no carry-in, so each nibble takes two adder passes: operands first, then the incoming carry.
- Sits between requesting datapath blocks and the single adder instance; the adder itself is external to this block.

---
 rtl/shared_nibble_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_shared_nibble_adder_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_nibble_adder_ctrl.sv
// ------------------------------------------------------------------------------
// shared_nibble_adder_ctrl - round-robin arbiter feeding one shared 4-bit adder,
// which performs a (4*NIBBLES)-bit addition nibble-serially, LSB nibble first.
// Revision: 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module shared_nibble_adder_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W:0]   result,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  input  logic [4:0]   add_sum
);

  localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD_AB = 2'd1,
    S_ADD_C  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_carry;
  logic                 r_s_cout;
  logic                 r_prio;
  logic                 r_id;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;

  logic                 w_idle;
  logic                 w_pick1;
  logic                 w_cnew;
  logic                 w_last;
  logic [c_idx_w-1:0]   w_nidx;
  logic [W-1:0]         w_sel_a;
  logic [W-1:0]         w_sel_b;

  // r_prio=0 favours req0 on contention; it flips to the other side on every grant
  assign w_idle  = (r_state == S_IDLE);
  assign w_pick1 = req1 & (~req0 | r_prio);
  assign gnt1    = rst_n & w_idle & w_pick1;
  assign gnt0    = rst_n & w_idle & req0 & ~w_pick1;

  assign w_sel_a = w_pick1 ? a1 : a0;
  assign w_sel_b = w_pick1 ? b1 : b0;

  assign w_cnew  = r_s_cout | add_sum[4];
  assign w_last  = (r_idx == c_last_idx);
  assign w_nidx  = r_idx + 1'b1;

  // add_a/add_b are registered one state ahead so the external adder sees
  // stable operands for the whole cycle of the state that consumes add_sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_s_cout <= 1'b0;
      r_prio   <= 1'b0;
      r_id     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      result   <= '0;
      add_a    <= 4'd0;
      add_b    <= 4'd0;
    end else begin
      done    <= 1'b0;
      done_id <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_pick1;
            r_prio  <= ~w_pick1;
            r_idx   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b1;
            add_a   <= w_sel_a[3:0];
            add_b   <= w_sel_b[3:0];
            r_state <= S_ADD_AB;
          end
        end

        S_ADD_AB: begin
          // Only the carry of the operand pass is kept; its low nibble goes straight to add_a.
          r_s_cout <= add_sum[4];
          add_a    <= add_sum[3:0];
          add_b    <= {3'b000, r_carry};
          r_state  <= S_ADD_C;
        end

        S_ADD_C: begin
          result[{r_idx, 2'b00} +: 4] <= add_sum[3:0];
          r_carry <= w_cnew;
          if (w_last) begin
            result[W] <= w_cnew;
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            done      <= 1'b1;
            done_id   <= r_id;
            r_state   <= S_DONE;
          end else begin
            r_idx   <= w_nidx;
            add_a   <= r_a[{w_nidx, 2'b00} +: 4];
            add_b   <= r_b[{w_nidx, 2'b00} +: 4];
            r_state <= S_ADD_AB;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shared_nibble_adder_ctrl.sv
// ------------------------------------------------------------------------------
// tb_shared_nibble_adder_ctrl - scoreboard bench for shared_nibble_adder_ctrl.
// Revision: 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module tb_shared_nibble_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [16:0] result;
  logic [3:0]  add_a, add_b;
  logic [4:0]  add_sum;

  // The shared adder itself lives outside the DUT.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  shared_nibble_adder_ctrl #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  typedef struct {
    logic        id;
    logic [16:0] res;
    int          gcyc;
  } sb_t;

  sb_t         sb[$];
  logic        gq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_done = -1;
  int          spacing_from = 0;
  bit          spacing_on = 0;
  logic [16:0] exp0 = '0;
  logic [16:0] exp1 = '0;
  sb_t         e;
  logic        gid;
  logic        eg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records grants into the scoreboard, checks every done against it.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (gnt0 || gnt1) begin
        gid = gnt1;
        if (gnt0 && gnt1) begin
          total++; bad++;
          $display("FAIL both_grants: gnt0=%b gnt1=%b need one-hot", gnt0, gnt1);
        end
        if (gq.size() > 0) begin
          eg = gq.pop_front();
          total++;
          if (gid !== eg) begin
            bad++;
            $display("FAIL grant_order: got %0d need %0d (cycle %0d)", gid, eg, cyc);
          end
        end
        if (spacing_on && last_done >= spacing_from) begin
          total++;
          if (cyc - last_done != 1) begin
            bad++;
            $display("FAIL grant_spacing: got %0d cycles after done need 1", cyc - last_done);
          end
        end
        sb.push_back('{id: gid, res: (gid ? exp1 : exp0), gcyc: cyc});
      end
      if (done) begin
        last_done = cyc;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got done=1 id=%0d result=%h need no done", done_id, result);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || done_id !== e.id || cyc != e.gcyc + 9 ||
              add_a !== 4'd0 || add_b !== 4'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_check: got result=%h id=%0d lat=%0d add_a=%h add_b=%h busy=%b need result=%h id=%0d lat=9 add=0 busy=1",
                     result, done_id, cyc - e.gcyc, add_a, add_b, busy, e.res, e.id);
          end
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] exp, output int gcyc);
    gq.push_back(id);
    if (id) begin a1 = a; b1 = b; exp1 = exp; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; exp0 = exp; req0 = 1'b1; end
    gcyc = -1;
    for (int k = 0; k < 40 && gcyc < 0; k++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) gcyc = cyc;
    end
    if (gcyc < 0) begin
      total++; bad++;
      $display("FAIL grant_timeout: got no gnt%0d need gnt within 40 cycles", id);
    end
    @(posedge clk); #1;
    // Operands change after capture; the result must not follow them.
    if (id) begin req1 = 1'b0; a1 = 16'hDEAD; b1 = 16'hBEEF; end
    else    begin req0 = 1'b0; a0 = 16'hDEAD; b0 = 16'hBEEF; end
  endtask

  // Per-cycle adder operands for the 8 cycles after the grant, nibble k = cycle k.
  task automatic trace(input logic [31:0] ea, input logic [31:0] eb, input string nm);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (add_a !== ea[4*k +: 4] || add_b !== eb[4*k +: 4] || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_trace k=%0d: got add_a=%h add_b=%h busy=%b need add_a=%h add_b=%h busy=1",
                 nm, k, add_a, add_b, busy, ea[4*k +: 4], eb[4*k +: 4]);
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_idle_timeout: got pending=%0d busy=%b need 0 0", nm, sb.size(), busy);
    end
  endtask

  task automatic check_zero(input string nm);
    total++;
    if ({gnt0, gnt1, busy, done, done_id} !== 5'b0 || result !== 17'h0 ||
        add_a !== 4'h0 || add_b !== 4'h0) begin
      bad++;
      $display("FAIL %s: got gnt=%b%b busy=%b done=%b id=%b result=%h add=%h/%h need all 0",
               nm, gnt0, gnt1, busy, done, done_id, result, add_a, add_b);
    end
  endtask

  initial begin
    int g;
    int cnt;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_state");

    // Both requesters held from reset: grants 0,1,0,1, each one cycle after a done.
    @(posedge clk); #1;
    rst_n = 1'b0;
    a0 = 16'h1234; b0 = 16'h4321; exp0 = 17'h05555;
    a1 = 16'hFFFF; b1 = 16'h0001; exp1 = 17'h10000;
    req0 = 1'b1; req1 = 1'b1;
    gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
    spacing_from = cyc;
    spacing_on = 1'b1;
    @(negedge clk);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL gnt_in_reset: got %b%b need 00", gnt0, gnt1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 4; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) cnt++;
    end
    if (cnt < 4) begin
      total++; bad++;
      $display("FAIL rr_grant_timeout: got %0d grants need 4", cnt);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("rr");
    spacing_on = 1'b0;

    issue(1'b0, 16'h1234, 16'h4321, 17'h05555, g);
    trace(32'h51525354, 32'h04030201, "t1");
    wait_idle("t1");

    issue(1'b1, 16'hFFFF, 16'h0001, 17'h10000, g);
    trace(32'hFFFFFF0F, 32'h10101001, "t2");
    wait_idle("t2");

    issue(1'b0, 16'h0F0F, 16'h0F01, 17'h01E10, g);
    trace(32'h00EF000F, 32'h100F1001, "t5");
    wait_idle("t5");
    repeat (3) @(negedge clk);
    total++;
    if (result !== 17'h01E10 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: got result=%h busy=%b done=%b need 01e10 0 0", result, busy, done);
    end

    // Abort in the third ADD_C pass: no done, everything back to reset values.
    issue(1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFFE, g);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (add_a !== 4'hE || add_b !== 4'h1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_point: got add_a=%h add_b=%h busy=%b need e 1 1", add_a, add_b, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_abort");
    repeat (12) @(negedge clk);

    issue(1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFE, g);
    wait_idle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
